// File: rtl/gpio_in_pkg.sv
// Shared widths and the per-pin filter state record for the GPIO input qualifier.
package gpio_in_pkg;

    localparam int IO_WIDTH     = 36;
    localparam int FILTER_WIDTH = 8;

    typedef struct packed {
        logic                    f;
        logic [FILTER_WIDTH-1:0] cnt;
        logic                    valid;
    } filter_state_t;

endpackage

// File: rtl/gpio_in_filter_bit.sv
// One pin of the input qualifier: two-flop resync, glitch filter with priming,
// polarity inversion and edge-event generation.
module gpio_in_filter_bit
    import gpio_in_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pin_async,
    input  logic [FILTER_WIDTH-1:0] filter_len,
    input  logic                    invert,
    input  logic                    rise_ena,
    input  logic                    fall_ena,
    output logic                    filt_data,
    output logic                    valid,
    output logic                    evt_set
);

    logic [1:0]              sync_q;
    logic [1:0]              warm_q;
    logic                    diff_q;
    logic                    diff_d;
    filter_state_t           state_q;
    filter_state_t           state_d;

    logic                    s2;
    logic                    diff;
    logic                    qualify;
    logic                    new_val;
    logic [FILTER_WIDTH-1:0] eff_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            warm_q  <= '0;
            diff_q  <= 1'b0;
            state_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], pin_async};
            warm_q  <= {warm_q[0], 1'b1};
            diff_q  <= diff_d;
            state_q <= state_d;
        end
    end

    // The same counter serves the stability count while priming and the change
    // count afterwards, so it restarts whenever the compare result flips.
    // Filtering waits until s2 carries a real sample, otherwise the reset zeros
    // in the synchroniser could prime a pin that is actually high.
    always_comb begin
        state_d = state_q;
        diff_d  = diff_q;
        qualify = 1'b0;
        s2      = sync_q[1];
        diff    = s2 ^ state_q.f;
        eff_cnt = (diff == diff_q) ? state_q.cnt : '0;
        if (warm_q[1]) begin
            diff_d = diff;
            if (eff_cnt >= filter_len) begin
                state_d.cnt   = '0;
                state_d.valid = 1'b1;
                if (diff) begin
                    state_d.f = s2;
                    qualify   = 1'b1;
                end
            end else if (diff || !state_q.valid) begin
                state_d.cnt = eff_cnt + FILTER_WIDTH'(1);
            end else begin
                state_d.cnt = '0;
            end
        end
    end

    always_comb begin
        new_val = s2 ^ invert;
        evt_set = qualify & state_q.valid &
                  ((new_val & rise_ena) | (~new_val & fall_ena));
    end

    assign filt_data = state_q.f ^ invert;
    assign valid     = state_q.valid;

endmodule

// File: rtl/gpio_in_qualifier.sv
// GPIO input qualifier: per-pin filtering plus sticky edge-event bits and an
// aggregate interrupt for the host.
module gpio_in_qualifier
    import gpio_in_pkg::*;
#(
    parameter int IOWidth     = IO_WIDTH,
    parameter int FilterWidth = FILTER_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IOWidth-1:0]     gpio_in_data,
    input  logic [FilterWidth-1:0] filter_len,
    input  logic [IOWidth-1:0]     invert,
    input  logic [IOWidth-1:0]     rise_ena,
    input  logic [IOWidth-1:0]     fall_ena,
    input  logic [IOWidth-1:0]     evt_clear,
    output logic [IOWidth-1:0]     filt_data,
    output logic [IOWidth-1:0]     evt_latch,
    output logic [IOWidth-1:0]     valid,
    output logic                   irq
);

    logic [IOWidth-1:0] evt_set;
    logic [IOWidth-1:0] evt_latch_q;
    logic [IOWidth-1:0] evt_latch_d;
    logic               irq_q;

    generate
        for (genvar gi = 0; gi < IOWidth; gi++) begin : g_pin
            gpio_in_filter_bit u_bit (
                .clk        (clk),
                .reset      (reset),
                .pin_async  (gpio_in_data[gi]),
                .filter_len (FILTER_WIDTH'(filter_len)),
                .invert     (invert[gi]),
                .rise_ena   (rise_ena[gi]),
                .fall_ena   (fall_ena[gi]),
                .filt_data  (filt_data[gi]),
                .valid      (valid[gi]),
                .evt_set    (evt_set[gi])
            );
        end
    endgenerate

    // A new event outranks a simultaneous clear so no edge is ever lost.
    always_comb begin
        evt_latch_d = evt_set | (evt_latch_q & ~evt_clear);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_latch_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            evt_latch_q <= evt_latch_d;
            irq_q       <= |evt_latch_q;
        end
    end

    assign evt_latch = evt_latch_q;
    assign irq       = irq_q;

endmodule
